// File: rtl/instr_encode_fifo.sv
// Packs opcode/register/constant fields into 32-bit Mini SRC words and queues them in a DEPTH-entry FIFO.
// One cycle from accept to head. in_ready drops only when the FIFO is full; range-rejected field sets are counted and dropped.
module instr_encode_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       fmt,
  input  logic [4:0]       opcode,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [CNT_W-1:0] level,
  output logic             imm_err,
  output logic [7:0]       err_count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_level;
  logic             r_imm_err;
  logic [7:0]       r_err_count;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  always_comb begin
    w_word = '0;
    case (fmt)
      2'd0:    w_word = {opcode, ra, rb, rc, 15'b0};
      2'd1:    w_word = {opcode, ra, rb, imm[18:0]};
      2'd2:    w_word = {opcode, ra, rb[3:0], imm[18:0]};
      default: w_word = {opcode, ra, 23'b0};
    endcase
  end

  // Only I and B carry a constant; it must sign-extend cleanly from bit 18.
  assign w_legal  = (fmt[1] ^ fmt[0]) ? ((&imm[31:18]) | ~(|imm[31:18])) : 1'b1;
  assign in_ready = (r_level != CNT_W'(DEPTH));
  assign w_accept = in_valid & in_ready;
  assign w_push   = w_accept & w_legal;
  assign out_valid = (r_level != '0);
  assign w_pop    = out_valid & out_ready;

  assign out_instr = out_valid ? r_mem[r_rd_ptr] : 32'b0;
  assign level     = r_level;
  assign imm_err   = r_imm_err;
  assign err_count = r_err_count;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_imm_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + CNT_W'(1);
        2'b01:   r_level <= r_level - CNT_W'(1);
        default: r_level <= r_level;
      endcase
      r_imm_err <= w_accept & ~w_legal;
      if (w_accept && !w_legal && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_instr_encode_fifo.sv
// Directed and random bench for instr_encode_fifo against a queue-based reference model.
module tb_instr_encode_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       fmt;
  logic [4:0]       opcode;
  logic [3:0]       ra, rb, rc;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [CNT_W-1:0] level;
  logic             imm_err;
  logic [7:0]       err_count;

  instr_encode_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .level(level), .imm_err(imm_err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_q[$];
  int          m_err = 0;
  bit          m_pulse = 0;

  function automatic logic [31:0] ref_enc(input int f, input int opc, input int a,
                                          input int b, input int c, input int k);
    longint w;
    longint kk;
    w = longint'(opc) * (64'd1 << 27) + longint'(a) * (64'd1 << 23);
    kk = ((longint'(k) % 524288) + 524288) % 524288;
    case (f)
      0: w = w + longint'(b) * (64'd1 << 19) + longint'(c) * (64'd1 << 15);
      1, 2: w = w + longint'(b) * (64'd1 << 19) + kk;
      default: ;
    endcase
    return w[31:0];
  endfunction

  function automatic bit ref_legal(input int f, input int k);
    if (f == 1 || f == 2) return (k >= -262144) && (k <= 262143);
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".level"},     32'(level),     32'(m_q.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() != DEPTH));
    check({tag, ".out_instr"}, out_instr,      (m_q.size() != 0) ? m_q[0] : 32'h0);
    check({tag, ".imm_err"},   32'(imm_err),   32'(m_pulse));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
  endtask

  // One clock: drive at negedge, advance the model at the edge, check #1 after it.
  task automatic step(input string tag, input bit v, input int f, input int opc, input int a,
                      input int b, input int c, input int k, input bit ordy);
    bit acc;
    bit pop;
    @(negedge clock);
    in_valid = v; fmt = 2'(f); opcode = 5'(opc); ra = 4'(a); rb = 4'(b); rc = 4'(c);
    imm = 32'(k); out_ready = ordy;
    acc = v && (m_q.size() < DEPTH);
    pop = ordy && (m_q.size() > 0);
    @(posedge clock);
    if (pop) void'(m_q.pop_front());
    m_pulse = 0;
    if (acc) begin
      if (ref_legal(f, k)) m_q.push_back(ref_enc(f, opc, a, b, c, k));
      else begin
        m_pulse = 1;
        if (m_err < 255) m_err++;
      end
    end
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag, input bit ordy);
    step(tag, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b0; in_valid = 0; fmt = 0; opcode = 0; ra = 0; rb = 0; rc = 0; imm = 0;
    out_ready = 0;
    #12;
    check_state("reset");
    @(negedge clock); clear = 1'b1;

    // R format
    step("r_push", 1, 0, 5'h03, 2, 4, 5, 0, 0);
    check("r_word", out_instr, 32'h19228000);
    idle("r_pop", 1);

    // I format, legal then out of range
    step("i_push", 1, 1, 5'h0C, 1, 2, 0, -5, 0);
    check("i_word", out_instr, 32'h6097FFFB);
    idle("i_pop", 1);
    step("i_bad", 1, 1, 5'h0C, 1, 2, 0, 32'h00040000, 0);
    idle("i_bad_after", 0);
    step("b_neg_edge", 1, 2, 5'h11, 7, 9, 0, -262144, 0);
    step("b_bad_neg", 1, 2, 5'h11, 7, 9, 0, -262145, 0);
    step("j_push", 1, 3, 5'h1F, 15, 3, 3, 32'hFFFFFFFF, 0);
    idle("drain0", 1);
    idle("drain1", 1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 4; i++) step("fill", 1, 0, i + 1, i, i + 2, i + 3, 0, 0);
    step("full_ignored", 1, 0, 5'h1E, 1, 1, 1, 0, 0);
    step("full_pop_no_push", 1, 0, 5'h1D, 2, 2, 2, 0, 1);
    for (int i = 0; i < 4; i++) idle("drain", 1);

    // Steady stream at level 2
    step("pre0", 1, 1, 5'h05, 1, 1, 0, 100, 0);
    step("pre1", 1, 1, 5'h05, 2, 2, 0, 200, 0);
    for (int i = 0; i < 10; i++) step("stream", 1, 1, 5'h06, i, 15 - i, 0, i * 1000 - 4000, 1);
    idle("s_drain0", 1);
    idle("s_drain1", 1);

    // Async clear at level 3
    for (int i = 0; i < 3; i++) step("pre_clr", 1, 0, 5'h09, i, i, i, 0, 0);
    step("pre_clr_bad", 1, 1, 5'h09, 0, 0, 0, 32'h7FFFFFFF, 0);
    @(negedge clock);
    in_valid = 0;
    clear = 1'b0;
    #1;
    m_q.delete(); m_err = 0; m_pulse = 0;
    check_state("clear_async");
    #2 clear = 1'b1;
    step("post_clr", 1, 0, 5'h0A, 3, 6, 9, 0, 0);
    check("post_clr_word", out_instr, ref_enc(0, 5'h0A, 3, 6, 9, 0));
    idle("post_clr_pop", 1);

    // Error counter saturation
    for (int i = 0; i < 260; i++) step("sat", 1, 1, 5'h01, 0, 0, 0, 32'h00100000, 1);
    check("sat_255", 32'(err_count), 32'd255);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      if ($urandom_range(0, 3) == 0) k = int'($urandom);
      else k = int'($urandom_range(0, 524287)) - 262144;
      step("rand", bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), k,
           bit'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
